// File: rtl/seg7_display_driver.sv
// -----------------------------------------------------------------------------
// seg7_display_driver
//
// Output stage of the calculator. A signed result from the arithmetic core is
// sampled on value_valid, converted to sign + BCD by an iterative shift-add-3
// (double-dabble) engine, and committed as four segment codes that are
// time-multiplexed onto a 4-digit common-anode 7-segment display.
//
// Parameters
//   VALUE_WIDTH    width of the signed (two's complement) input value
//   REFRESH_CYCLES clk cycles each digit stays lit (>= 2)
//   POINT_DIGIT    digit index (0 = rightmost) whose DP lights when point is set
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   value       in   signed result to display
//   value_valid in   one-cycle strobe, samples value/error/point
//   error       in   show the "E" glyph instead of the value
//   point       in   light DP on digit POINT_DIGIT (value is result x100)
//   busy        out  conversion in progress
//   anodes      out  active-low digit enables, bit0 = rightmost digit
//   segments    out  active-low {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_display_driver #(
   parameter int VALUE_WIDTH    = 16,
   parameter int REFRESH_CYCLES = 50000,
   parameter int POINT_DIGIT    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic signed [VALUE_WIDTH-1:0] value,
   input  logic                          value_valid,
   input  logic                          error,
   input  logic                          point,
   output logic                          busy,
   output logic [3:0]                    anodes,
   output logic [7:0]                    segments
);

   // Enough BCD digits to hold |value| for any width (log10(2) ~ 0.301),
   // never fewer than the four digits the display needs.
   localparam int BCD_RAW    = (VALUE_WIDTH * 301) / 1000 + 1;
   localparam int BCD_DIGITS = (BCD_RAW < 4) ? 4 : BCD_RAW;
   localparam int BCD_W      = 4 * BCD_DIGITS;
   localparam int ITER_W     = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
   localparam int CNT_W      = $clog2(REFRESH_CYCLES);

   localparam logic [7:0] GLYPH_ZERO  = 8'hC0;
   localparam logic [7:0] GLYPH_MINUS = 8'hBF;
   localparam logic [7:0] GLYPH_E     = 8'h86;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_COMMIT
   } state_t;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Active-low segment pattern for a decimal digit, DP off.
   function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
      logic [7:0] g;
      case (digit)
         4'd0:    g = 8'hC0;
         4'd1:    g = 8'hF9;
         4'd2:    g = 8'hA4;
         4'd3:    g = 8'hB0;
         4'd4:    g = 8'h99;
         4'd5:    g = 8'h92;
         4'd6:    g = 8'h82;
         4'd7:    g = 8'hF8;
         4'd8:    g = 8'h80;
         4'd9:    g = 8'h90;
         default: g = 8'hFF;
      endcase
      return g;
   endfunction

   // One double-dabble iteration: correct every nibble >= 5 by +3, then shift
   // the combined {bcd, magnitude} register left by one bit.
   function automatic logic [BCD_W+VALUE_WIDTH-1:0] dabble_step(
      input logic [BCD_W-1:0]       bcd,
      input logic [VALUE_WIDTH-1:0] mag
   );
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end
      end
      return {adj, mag} << 1;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                   state;
   logic [ITER_W-1:0]        iter_cnt;
   logic [BCD_W-1:0]         bcd_q;
   logic [VALUE_WIDTH-1:0]   mag_q;
   logic                     err_q;
   logic                     oor_q;
   logic                     neg_q;
   logic                     point_q;
   logic [3:0][7:0]          disp_q;
   logic [CNT_W-1:0]         refresh_cnt;
   logic [1:0]               scan_idx;

   // ---------------------------------------------------------------------------
   // Sample-side decode
   // ---------------------------------------------------------------------------
   logic signed [31:0]       value_ext;
   logic                     oor_in;
   logic [VALUE_WIDTH-1:0]   mag_in;

   assign value_ext = 32'(value);
   // Four digits can show 0..9999, or a minus sign plus 0..999.
   assign oor_in    = (value_ext > 32'sd9999) || (value_ext < -32'sd999);
   // The most-negative value negates to itself, which as an unsigned
   // magnitude is still correct (and is flagged out of range anyway).
   assign mag_in    = value[VALUE_WIDTH-1] ? (~value + VALUE_WIDTH'(1)) : value;

   // ---------------------------------------------------------------------------
   // Commit codes built from the finished BCD accumulator
   // ---------------------------------------------------------------------------
   logic [3:0][7:0] commit_codes;

   always_comb begin
      commit_codes = {4{GLYPH_ZERO}};
      if (err_q || oor_q) begin
         commit_codes[0] = GLYPH_E;
      end else begin
         commit_codes[0] = seg_glyph(bcd_q[3:0]);
         commit_codes[1] = seg_glyph(bcd_q[7:4]);
         commit_codes[2] = seg_glyph(bcd_q[11:8]);
         commit_codes[3] = neg_q ? GLYPH_MINUS : seg_glyph(bcd_q[15:12]);
         if (point_q) begin
            commit_codes[POINT_DIGIT][7] = 1'b0;
         end
      end
   end

   // A new sample arriving in the COMMIT cycle wins: the stale result is
   // dropped rather than briefly shown.
   logic            do_commit;
   logic [3:0][7:0] disp_next;
   logic            refresh_tc;
   logic [1:0]      scan_next;

   assign do_commit  = (state == S_COMMIT) && !value_valid;
   assign disp_next  = do_commit ? commit_codes : disp_q;
   assign refresh_tc = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));
   assign scan_next  = refresh_tc ? (scan_idx + 2'd1) : scan_idx;

   // ---------------------------------------------------------------------------
   // Control, display and scan registers
   // ---------------------------------------------------------------------------
   // anodes and segments are both loaded from next-state values so they move
   // on the same edge; a commit shows up on the lit digit immediately.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         iter_cnt    <= '0;
         disp_q      <= {4{GLYPH_ZERO}};
         refresh_cnt <= '0;
         scan_idx    <= 2'd0;
         anodes      <= 4'b1110;
         segments    <= GLYPH_ZERO;
      end else begin
         refresh_cnt <= refresh_tc ? '0 : refresh_cnt + CNT_W'(1);
         scan_idx    <= scan_next;
         disp_q      <= disp_next;
         anodes      <= ~(4'b0001 << scan_next);
         segments    <= disp_next[scan_next];

         if (value_valid) begin
            // Start (or restart) a conversion with the latest sample.
            state    <= S_CONVERT;
            iter_cnt <= '0;
            busy     <= 1'b1;
         end else begin
            case (state)
               S_CONVERT: begin
                  iter_cnt <= iter_cnt + ITER_W'(1);
                  if (iter_cnt == ITER_W'(VALUE_WIDTH - 1)) begin
                     state <= S_COMMIT;
                  end
               end
               S_COMMIT: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Conversion datapath (no reset: only read after a sample has loaded it)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (value_valid) begin
         mag_q   <= mag_in;
         bcd_q   <= '0;
         err_q   <= error;
         oor_q   <= oor_in;
         neg_q   <= value[VALUE_WIDTH-1];
         point_q <= point;
      end else if (state == S_CONVERT) begin
         {bcd_q, mag_q} <= dabble_step(bcd_q, mag_q);
      end
   end

endmodule

// File: tb/tb_seg7_display_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_driver
//
// Scoreboard bench: the stimulus pushes the expected four digit codes and the
// expected busy length for each sample; a monitor detects each commit (busy
// falling outside reset), captures one full scan frame and compares it.
// -----------------------------------------------------------------------------
module tb_seg7_display_driver;

   localparam int VW = 16;
   localparam int RC = 4;
   localparam int PD = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic signed [VW-1:0] value;
   logic                 value_valid;
   logic                 error;
   logic                 point;
   logic                 busy;
   logic [3:0]           anodes;
   logic [7:0]           segments;

   always #5 clk = ~clk;

   seg7_display_driver #(
      .VALUE_WIDTH   (VW),
      .REFRESH_CYCLES(RC),
      .POINT_DIGIT   (PD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .value_valid(value_valid),
      .error      (error),
      .point      (point),
      .busy       (busy),
      .anodes     (anodes),
      .segments   (segments)
   );

   typedef struct {
      logic [31:0] codes;     // {digit3, digit2, digit1, digit0}
      int          busy_len;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   passes  = 0;
   int   handled = 0;
   int   issued  = 0;
   int   ghost   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   function automatic int anode_idx(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   // Samples one full scan (4 digit periods) starting at the current negedge.
   task automatic capture_frame(output logic [31:0] codes, output int bad);
      logic [3:0] seen;
      int         idx;
      seen  = 4'h0;
      codes = '0;
      bad   = 0;
      for (int c = 0; c < 4 * RC; c++) begin
         if (c != 0) @(negedge clk);
         idx = anode_idx(anodes);
         if (idx < 0) bad++;
         else begin
            if (seen[idx] && (codes[8*idx +: 8] !== segments)) bad++;
            codes[8*idx +: 8] = segments;
            seen[idx] = 1'b1;
         end
      end
      if (seen != 4'hF) bad++;
   endtask

   // Exactly one anode low whenever out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && anode_idx(anodes) < 0) ghost++;
   end

   // Monitor: one scoreboard entry per commit.
   initial begin : monitor
      int          run;
      logic        prev;
      exp_t        e;
      logic [31:0] got;
      int          bad;
      run  = 0;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            run  = 0;
            prev = 1'b0;
         end else if (busy === 1'b1) begin
            run++;
            prev = 1'b1;
         end else begin
            if (prev) begin
               check("commit_expected", 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("busy_len", run, e.busy_len);
                  capture_frame(got, bad);
                  check("frame_stable", bad, 0);
                  for (int d = 0; d < 4; d++)
                     check($sformatf("digit%0d", d), 32'(got[8*d +: 8]), 32'(e.codes[8*d +: 8]));
               end
               handled++;
            end
            run  = 0;
            prev = 1'b0;
         end
      end
   end

   task automatic send(input logic signed [VW-1:0] v, input logic e, input logic p);
      @(posedge clk);
      #1;
      value       = v;
      error       = e;
      point       = p;
      value_valid = 1'b1;
      @(posedge clk);
      #1;
      value_valid = 1'b0;
   endtask

   task automatic wait_handled(input string name);
      int t;
      t = 0;
      while (handled < issued && t < 200) begin
         @(posedge clk);
         t++;
      end
      check({name, "_done"}, 32'(handled >= issued), 32'd1);
      repeat (3) @(posedge clk);
   endtask

   task automatic run_vec(input string name, input logic signed [VW-1:0] v,
                          input logic e, input logic p, input logic [31:0] codes);
      sb.push_back('{codes, VW + 1});
      issued++;
      send(v, e, p);
      wait_handled(name);
   endtask

   initial begin : stimulus
      logic [31:0] got;
      int          bad;
      rst_n       = 1'b0;
      value_valid = 1'b0;
      value       = '0;
      error       = 1'b0;
      point       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_anodes", 32'(anodes), 32'h0000000E);
      check("rst_segments", 32'(segments), 32'h000000C0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Scan sequence after reset: 1101, 1011, 0111, back to 1110
      for (int k = 1; k <= 4; k++) begin
         logic [3:0] exp_an;
         exp_an = ~(4'b0001 << (k % 4));
         repeat (RC) @(posedge clk);
         @(negedge clk);
         check($sformatf("scan%0d_anodes", k), 32'(anodes), 32'(exp_an));
         check($sformatf("scan%0d_segments", k), 32'(segments), 32'h000000C0);
      end

      // Directed vectors
      run_vec("v225",      16'sd225,    1'b0, 1'b0, 32'hC0A4A492);
      run_vec("vneg15",    -16'sd15,    1'b0, 1'b0, 32'hBFC0F992);
      run_vec("v1500pt",   16'sd1500,   1'b0, 1'b1, 32'hF912C0C0);
      run_vec("verr1234",  16'sd1234,   1'b1, 1'b0, 32'hC0C0C086);
      run_vec("v10000",    16'sd10000,  1'b0, 1'b0, 32'hC0C0C086);
      run_vec("v9999",     16'sd9999,   1'b0, 1'b0, 32'h90909090);
      run_vec("v3647",     16'sd3647,   1'b0, 1'b0, 32'hB08299F8);
      run_vec("vneg999",   -16'sd999,   1'b0, 1'b0, 32'hBF909090);
      run_vec("vneg1000",  -16'sd1000,  1'b0, 1'b0, 32'hC0C0C086);
      run_vec("vmostneg",  -16'sd32768, 1'b0, 1'b0, 32'hC0C0C086);
      run_vec("v0pt",      16'sd0,      1'b0, 1'b1, 32'hC040C0C0);
      run_vec("verrpt",    16'sd1234,   1'b1, 1'b1, 32'hC0C0C086);
      run_vec("vneg5pt",   -16'sd5,     1'b0, 1'b1, 32'hBF40C092);

      // Restart: 7 then 9 four cycles later; only 9 may ever be committed
      sb.push_back('{32'hC0C0C090, VW + 5});
      issued++;
      send(16'sd7, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      send(16'sd9, 1'b0, 1'b0);
      wait_handled("restart");

      // Reset in the middle of a conversion: display returns to 0000
      send(16'sd1234, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      capture_frame(got, bad);
      check("midrst_frame_stable", bad, 0);
      check("midrst_frame", got, 32'hC0C0C0C0);
      repeat (30) @(posedge clk);
      check("midrst_no_commit", handled, issued);

      check("anode_onehot", ghost, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seg7_display_driver.md
Name: seg7_display_driver

Overview:
- Downstream output stage of the calculator: takes the signed result from the arithmetic core and drives the 4-digit multiplexed 7-segment display.
- Converts the result to sign/BCD with an iterative shift-add-3 (double-dabble) engine.
- Time-multiplexes the four active-low anodes and produces the active-low segment/decimal-point pattern, including minus sign, "E" error glyph and a fixed decimal point for division results.

Parameters:
- VALUE_WIDTH, 16, width of signed input value (two's complement).
- REFRESH_CYCLES, 50000, clk cycles each digit stays lit (1 ms at 50 MHz); minimum legal value 2.
- POINT_DIGIT, 2, digit index (0 = rightmost) whose DP lights when point is set.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- value  in  VALUE_WIDTH  signed result to display
- value_valid  in  1  one-cycle strobe; samples value/error/point
- error  in  1  show error glyph instead of value
- point  in  1  light DP on digit POINT_DIGIT (value is result x100)
- busy  out  1  conversion in progress
- anodes  out  4  active-low digit enables, bit0 = rightmost digit
- segments  out  8  active-low {dp,g,f,e,d,c,b,a}

Behaviour:
- Synchronous reset (rst_n=0 at a clk edge):
  - display registers = "0000", no point, no error
  - scan index 0; anodes=4'b1110, segments=8'b11000000, busy=0
  - refresh counter cleared
  - reset mid-conversion discards the conversion.
- Glyphs:
  - digits 0-9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex)
  - minus: BF
  - E: 86
  - DP clears bit7 (e.g. pointed 1 = 79).
- FSM:
  - IDLE: on value_valid, latch error/point, take magnitude = |value|, BCD accumulator = 0, go to CONVERT; busy=1 from next cycle.
  - CONVERT: exactly VALUE_WIDTH iterations. Each iteration: add 3 to any BCD nibble >=5, then shift {bcd, magnitude} left by 1. Then go to COMMIT.
  - COMMIT: one cycle; atomically writes the four display digit codes; busy=0 next cycle; go to IDLE.
  - Latency: value_valid at cycle T -> display registers updated at T+VALUE_WIDTH+2; busy high T+1..T+VALUE_WIDTH+1.
- value_valid while busy: restarts conversion with the new sample (latest wins); the old result is never committed.
- Display content:
  - error=1 or out of range (value>9999 or value<-999): digit0=E, digits1-3=0, point ignored.
  - value>=0: digits3..0 = thousands, hundreds, tens, units; leading zeros shown.
  - value<0: digit3=minus, digits2..0 = magnitude hundreds, tens, units.
  - point=1 and not error: DP cleared on digit POINT_DIGIT only.
  - Most-negative value (-2^(VALUE_WIDTH-1)) is out of range and shows E.
- Scanning:
  - Refresh counter counts 0..REFRESH_CYCLES-1; at terminal count, scan index increments 0->1->2->3->0.
  - anodes = ~(1<<index) always exactly one low; sequence 1110,1101,1011,0111, wrap.
  - anodes and segments are both registered and change on the same clk edge; no blank or ghost states.
  - A commit mid-digit changes segments immediately for the current index; anodes unaffected.
  - Scanning runs independently of the FSM.

Test Plan:
- Reset: hold rst_n=0 3 cycles -> anodes=1110, segments=C0, busy=0; after REFRESH_CYCLES cycles, anodes=1101 with segments C0; anodes wrap to 1110 after 4 periods.
- value=225, valid pulse -> busy high 17 cycles; afterwards digits read 0,2,2,5 (anode 0111..1110: C0,A4,A4,92).
- value=-15 -> anode 0111 shows BF, 1011 C0, 1101 F9, 1110 92.
- value=1500, point=1 -> digit2 (anode 1011) shows 12 (pointed 5), digit3 F9, digits1,0 C0; no other DP lit.
- error=1, value=1234 -> 1110 shows 86, all others C0; value=10000 (no error) -> same pattern.
- Restart case: valid with 7, then valid with 9 four cycles later -> units digit goes directly to 90, never F8; reset asserted mid-conversion -> display returns to 0000.
